// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: default widths,
// FSM state encoding, branch jump table and the ROM content function.
package fetch_pkg;

  localparam int unsigned PC_W_DEF    = 10;
  localparam int unsigned INSTR_W_DEF = 9;
  localparam int unsigned LUT_DEPTH   = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } fetch_state_e;

  localparam logic [PC_W_DEF-1:0] BRANCH_LUT [LUT_DEPTH] = '{
    10'h000, 10'h010, 10'h040, 10'h080, 10'h0C0, 10'h100, 10'h140, 10'h180,
    10'h1C0, 10'h200, 10'h240, 10'h280, 10'h2C0, 10'h300, 10'h380, 10'h3FE
  };

  // Program image: word at address a holds a+1 (truncated by the ROM width).
  function automatic logic [31:0] rom_word(input int unsigned addr);
    return 32'(addr) + 32'd1;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch <-> decode bus: control from decode, instruction stream back to decode.
interface instr_fetch_if
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W    = PC_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF
);
  logic               start;
  logic               stall;
  logic               branch_en;
  logic [PC_W-1:0]    branch_target;
  logic               halt_req;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic [PC_W-1:0]    pc_out;
  logic               halt;

  modport master (
    output start, stall, branch_en, branch_target, halt_req,
    input  instr, instr_valid, pc_out, halt
  );

  modport slave (
    input  start, stall, branch_en, branch_target, halt_req,
    output instr, instr_valid, pc_out, halt
  );
endinterface

// File: rtl/instr_fetch_rom.sv
// Synchronous-read program ROM, 2^ADDR_W x DATA_W: registered address,
// registered data one enabled edge later; both hold while i_en is low.
module instr_rom
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = PC_W_DEF,
  parameter int unsigned DATA_W = INSTR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] o_data
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] w_mem [DEPTH];
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    assign w_mem[g] = DATA_W'(rom_word(g));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
      r_data <= '0;
    end else if (i_en) begin
      r_addr <= i_addr;
      r_data <= w_mem[r_addr];
    end
  end

  assign o_data = r_data;
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: IDLE/RUN/HALTED sequencer, fetch PC and output stage.
// Build option BRANCH_LUT_EN: branch_target[3:0] indexes the package jump table.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W    = PC_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  instr_fetch_if.slave fetch_bus
);
  fetch_state_e       r_state, w_state_nxt;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    r_a_pc;
  logic               r_a_valid;
  logic [PC_W-1:0]    r_pc_out;
  logic               r_instr_valid;
  logic [PC_W-1:0]    w_target;
  logic [PC_W-1:0]    w_fetch_addr;
  logic [INSTR_W-1:0] w_rom_data;
  logic               w_adv;
  logic               w_branch;
  logic               w_halt_now;
  logic               w_start_run;

`ifdef BRANCH_LUT_EN
  logic w_unused_tgt;
  assign w_target     = PC_W'(BRANCH_LUT[fetch_bus.branch_target[3:0]]);
  assign w_unused_tgt = ^fetch_bus.branch_target[PC_W-1:4];
`else
  assign w_target = fetch_bus.branch_target;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_adv       = 1'b0;
    w_branch    = 1'b0;
    w_halt_now  = 1'b0;
    w_start_run = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (fetch_bus.start) begin
          w_state_nxt = S_RUN;
          w_start_run = 1'b1;
        end
      end
      S_RUN: begin
        if (fetch_bus.halt_req) begin
          w_state_nxt = S_HALTED;
          w_halt_now  = 1'b1;
        end else if (!fetch_bus.stall) begin
          w_adv    = 1'b1;
          w_branch = fetch_bus.branch_en;
        end
      end
      S_HALTED: begin
        if (!fetch_bus.start) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A taken branch goes straight into the ROM address register so only the
  // one sequential word already in the ROM is squashed.
  assign w_fetch_addr = w_branch ? w_target : r_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= '0;
      r_a_pc        <= '0;
      r_a_valid     <= 1'b0;
      r_pc_out      <= '0;
      r_instr_valid <= 1'b0;
    end else if (w_adv) begin
      r_pc          <= w_fetch_addr + PC_W'(1);
      r_a_pc        <= w_fetch_addr;
      r_a_valid     <= 1'b1;
      r_pc_out      <= r_a_pc;
      r_instr_valid <= r_a_valid & ~w_branch;
    end else if (r_state != S_RUN || w_halt_now) begin
      r_a_valid     <= 1'b0;
      r_instr_valid <= 1'b0;
      if (w_start_run) r_pc <= '0;
    end
  end

  instr_rom #(
    .ADDR_W (PC_W),
    .DATA_W (INSTR_W)
  ) u_rom (
    .clk    (clk),
    .rst    (reset),
    .i_en   (w_adv),
    .i_addr (w_fetch_addr),
    .o_data (w_rom_data)
  );

  assign fetch_bus.instr       = w_rom_data;
  assign fetch_bus.instr_valid = r_instr_valid;
  assign fetch_bus.pc_out      = r_pc_out;
  assign fetch_bus.halt        = (r_state == S_HALTED);
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: expected instruction stream held in a
// scoreboard queue, popped whenever the fetch unit should emit a word.
module tb_instr_fetch;
  logic clk;
  logic reset;
  int unsigned nchk;
  int unsigned nerr;
  int unsigned exp_q[$];
  int unsigned last_pc;
  logic [9:0] tgt_a;
  logic [9:0] tgt_w;

  instr_fetch_if #(.PC_W(10), .INSTR_W(9)) fbus ();

  instr_fetch #(.PC_W(10), .INSTR_W(9)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .fetch_bus (fbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag);
    int unsigned e;
    nchk++;
    assert (exp_q.size() != 0) else begin
      nerr++;
      $error("FAIL %s scoreboard empty observed pc=%0h expected=entry", tag, fbus.pc_out);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      last_pc = e;
      chk({tag, "_pc"}, 32'(fbus.pc_out), e);
      chk({tag, "_instr"}, 32'(fbus.instr), (e + 1) & 32'h1FF);
      chk({tag, "_valid"}, 32'(fbus.instr_valid), 32'd1);
    end
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    last_pc = 0;
`ifdef BRANCH_LUT_EN
    tgt_a = 10'd2;
    tgt_w = 10'd15;
`else
    tgt_a = 10'h040;
    tgt_w = 10'h3FE;
`endif
    reset               = 1'b1;
    fbus.start          = 1'b0;
    fbus.stall          = 1'b0;
    fbus.branch_en      = 1'b0;
    fbus.branch_target  = '0;
    fbus.halt_req       = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(fbus.instr_valid), 0);
    chk("rst_halt", 32'(fbus.halt), 0);
    chk("rst_pc", 32'(fbus.pc_out), 0);
    chk("rst_instr", 32'(fbus.instr), 0);

    // Start: first word two cycles after start is sampled.
    reset = 1'b0;
    fbus.start = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(i);
    tick();
    chk("lat0_valid", 32'(fbus.instr_valid), 0);
    tick();
    chk("lat1_valid", 32'(fbus.instr_valid), 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      pop_chk("seq");
    end

    // Three-cycle stall at pc_out=5.
    fbus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", 32'(fbus.pc_out), 5);
      chk("stall_instr", 32'(fbus.instr), 6);
      chk("stall_valid", 32'(fbus.instr_valid), 1);
    end
    fbus.stall = 1'b0;
    tick();
    pop_chk("post_stall");
    tick();
    pop_chk("pre_branch");

    // Branch at pc_out=7.
    fbus.branch_en = 1'b1;
    fbus.branch_target = tgt_a;
    exp_q.push_back(32'h040);
    exp_q.push_back(32'h041);
    tick();
    chk("br_squash", 32'(fbus.instr_valid), 0);
    fbus.branch_en = 1'b0;
    tick();
    pop_chk("br_tgt");
    tick();
    pop_chk("br_next");

    // PC wrap from 0x3FF to 0x000.
    fbus.branch_en = 1'b1;
    fbus.branch_target = tgt_w;
    exp_q.push_back(32'h3FE);
    exp_q.push_back(32'h3FF);
    exp_q.push_back(32'h000);
    exp_q.push_back(32'h001);
    tick();
    chk("wrap_squash", 32'(fbus.instr_valid), 0);
    fbus.branch_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      pop_chk("wrap");
    end

    // Halt beats branch and stall.
    fbus.halt_req = 1'b1;
    fbus.branch_en = 1'b1;
    fbus.stall = 1'b1;
    fbus.branch_target = 10'h123;
    tick();
    chk("halt_halt", 32'(fbus.halt), 1);
    chk("halt_valid", 32'(fbus.instr_valid), 0);
    chk("halt_pc", 32'(fbus.pc_out), last_pc);
    fbus.halt_req = 1'b0;
    fbus.branch_en = 1'b0;
    fbus.stall = 1'b0;
    tick();
    chk("halted_hold", 32'(fbus.halt), 1);
    chk("halted_valid", 32'(fbus.instr_valid), 0);
    fbus.start = 1'b0;
    tick();
    chk("idle_halt", 32'(fbus.halt), 0);
    chk("idle_valid", 32'(fbus.instr_valid), 0);
    fbus.start = 1'b1;
    exp_q.push_back(0);
    exp_q.push_back(1);
    tick();
    chk("rst0_valid", 32'(fbus.instr_valid), 0);
    tick();
    chk("rst1_valid", 32'(fbus.instr_valid), 0);
    tick();
    pop_chk("restart");
    tick();
    pop_chk("restart");

    // Reset during a stall, start still high.
    fbus.stall = 1'b1;
    tick();
    chk("pre_rst_valid", 32'(fbus.instr_valid), 1);
    reset = 1'b1;
    tick();
    chk("srst_valid", 32'(fbus.instr_valid), 0);
    chk("srst_halt", 32'(fbus.halt), 0);
    chk("srst_pc", 32'(fbus.pc_out), 0);
    chk("srst_instr", 32'(fbus.instr), 0);
    tick();
    chk("srst_hold_valid", 32'(fbus.instr_valid), 0);
    reset = 1'b0;
    fbus.stall = 1'b0;
    exp_q.push_back(0);
    tick();
    chk("srst_lat0", 32'(fbus.instr_valid), 0);
    tick();
    chk("srst_lat1", 32'(fbus.instr_valid), 0);
    tick();
    pop_chk("srst_first");

    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
